store_dispatch: RTL and testbench

// Upstream of the per-unit store FSMs. Buffers fifo_ctrl store transactions in an in-order FIFO.

---
 rtl/fifo_ctrl_pkg.sv | 27 ++
 rtl/store_dispatch_if.sv | 27 ++
 rtl/fifo_ctrl_sync_fifo.sv | 45 ++++
 rtl/store_dispatch.sv | 106 ++++++++++
 tb/tb_store_dispatch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared transaction types between fifo_ctrl and the store units, plus the
// address-interleave helper used to pick a store unit.
package fifo_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } transact_o_t;

    typedef struct packed {
        logic ready;
    } transact_i_t;

    // Unit index = the address field just above the line offset.
    function automatic int unsigned unit_sel(input logic [ADDR_W-1:0] addr,
                                             input int unsigned        line_offset,
                                             input int unsigned        num_units);
        logic [ADDR_W-1:0] shifted;
        shifted = addr >> line_offset;
        return 32'(shifted) & (num_units - 1);
    endfunction

endpackage

// File: rtl/store_dispatch_if.sv
// Handshake bundle between fifo_ctrl, the dispatcher and the per-unit store FSMs.
interface store_dispatch_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = 4
) ();

    transact_o_t transact_i;
    transact_i_t transact_o;
    transact_o_t unit_transact_o [NUM_UNITS];
    transact_i_t unit_transact_i [NUM_UNITS];

    modport slave (
        input  transact_i,
        output transact_o,
        output unit_transact_o,
        input  unit_transact_i
    );

    modport master (
        output transact_i,
        input  transact_o,
        input  unit_transact_o,
        output unit_transact_i
    );

endinterface

// File: rtl/fifo_ctrl_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is read combinationally.
module fifo_ctrl_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count = wr_ptr - rd_ptr;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/store_dispatch.sv
// In-order store buffer that steers each store to a unit chosen by address
// interleave, with one registered request slot per unit.
module store_dispatch
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int DEPTH       = 8,
    parameter int LINE_OFFSET = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    store_dispatch_if.slave        bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   idle,
    output logic [31:0]            hol_stall_cnt
);

    localparam int UNIT_W = $clog2(NUM_UNITS);
    localparam int WORD_W = ADDR_W + DATA_W;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head_word;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [UNIT_W-1:0] tgt;
    logic              head_blocked;

    logic [NUM_UNITS-1:0] slot_valid;
    logic [NUM_UNITS-1:0] slot_free;
    logic [NUM_UNITS-1:0] unit_rdy;
    logic [ADDR_W-1:0]    slot_addr [NUM_UNITS];
    logic [DATA_W-1:0]    slot_data [NUM_UNITS];

    // Ready depends only on registered FIFO state and reset, never on unit readies.
    assign bus.transact_o.ready = !fifo_full && !rst;
    assign push = bus.transact_i.valid && bus.transact_o.ready;

    fifo_ctrl_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.transact_i.addr, bus.transact_i.data}),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign head_addr    = head_word[WORD_W-1:DATA_W];
    assign head_data    = head_word[DATA_W-1:0];
    assign tgt          = UNIT_W'(unit_sel(head_addr, LINE_OFFSET, NUM_UNITS));
    assign pop          = !fifo_empty && slot_free[tgt];
    assign head_blocked = !fifo_empty && !slot_free[tgt];

    genvar k;
    generate
        for (k = 0; k < NUM_UNITS; k++) begin : g_slot
            assign unit_rdy[k]  = bus.unit_transact_i[k].ready;
            // A slot draining this cycle can take the next store on the same edge.
            assign slot_free[k] = !slot_valid[k] || unit_rdy[k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_valid[k] <= 1'b0;
                end else if (pop && (tgt == UNIT_W'(k))) begin
                    slot_valid[k] <= 1'b1;
                end else if (unit_rdy[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (pop && (tgt == UNIT_W'(k))) begin
                    slot_addr[k] <= head_addr;
                    slot_data[k] <= head_data;
                end
            end

            assign bus.unit_transact_o[k] = '{valid: slot_valid[k],
                                              addr:  slot_addr[k],
                                              data:  slot_data[k]};

            a_slot_stable: assert property (@(posedge clk) disable iff (rst)
                (slot_valid[k] && !unit_rdy[k]) |=>
                (slot_valid[k] && $stable(slot_addr[k]) && $stable(slot_data[k])));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hol_stall_cnt <= '0;
        end else if (head_blocked && (hol_stall_cnt != 32'hFFFF_FFFF)) begin
            hol_stall_cnt <= hol_stall_cnt + 32'd1;
        end
    end

    assign idle = fifo_empty && ~|slot_valid;

endmodule

// File: tb/tb_store_dispatch.sv
// Directed bench for store_dispatch: reset, steering, backpressure, full FIFO
// and head-of-line stall counting.
module tb_store_dispatch;
    import fifo_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  occupancy;
    logic        idle;
    logic [31:0] hol_stall_cnt;

    int passed = 0;
    int total  = 0;

    store_dispatch_if #(.NUM_UNITS(4)) bus ();

    store_dispatch #(
        .NUM_UNITS   (4),
        .DEPTH       (8),
        .LINE_OFFSET (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .occupancy     (occupancy),
        .idle          (idle),
        .hol_stall_cnt (hol_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] m);
        for (int k = 0; k < 4; k++) bus.unit_transact_i[k].ready = m[k];
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d);
        bus.transact_i = '{valid: v, addr: a, data: d};
    endtask

    function automatic logic [3:0] valids();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = bus.unit_transact_o[k].valid;
        return v;
    endfunction

    task automatic drain();
        int n = 0;
        drive(1'b0, 32'h0, 32'h0);
        set_ready(4'hF);
        #1;
        while (!idle && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (idle !== 1'b1) $display("FAIL drain_timeout idle=%0b occ=%0d", idle, occupancy);
        else passed++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0);
        set_ready(4'h0);
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.transact_o.ready !== 1'b0) $display("FAIL rst_ready got=%0b exp=0", bus.transact_o.ready); else passed++;
        total++; if (occupancy !== 4'd0) $display("FAIL rst_occ got=%0d exp=0", occupancy); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL rst_idle got=%0b exp=1", idle); else passed++;
        total++; if (valids() !== 4'h0) $display("FAIL rst_valids got=%b exp=0000", valids()); else passed++;
        total++; if (hol_stall_cnt !== 32'd0) $display("FAIL rst_hol got=%0d exp=0", hol_stall_cnt); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus.transact_o.ready !== 1'b1) $display("FAIL rst_release_ready got=%0b exp=1", bus.transact_o.ready); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        set_ready(4'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0, 32'h10 + i);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (occupancy !== 4'd3) $display("FAIL burst_occ got=%0d exp=3", occupancy); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus.transact_o.ready !== 1'b0) $display("FAIL midrst_ready got=%0b exp=0", bus.transact_o.ready); else passed++;
        total++; if (occupancy !== 4'd0) $display("FAIL midrst_occ got=%0d exp=0", occupancy); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL midrst_idle got=%0b exp=1", idle); else passed++;
        total++; if (valids() !== 4'h0) $display("FAIL midrst_valids got=%b exp=0000", valids()); else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.transact_o.ready !== 1'b1) $display("FAIL midrst_release got=%0b exp=1", bus.transact_o.ready); else passed++;
    endtask

    task automatic test_single();
        set_ready(4'hF);
        drive(1'b1, 32'h40, 32'h1111);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (occupancy !== 4'd1) $display("FAIL single_occ got=%0d exp=1", occupancy); else passed++;
        total++; if (valids() !== 4'h0) $display("FAIL single_early got=%b exp=0000", valids()); else passed++;
        tick();
        total++; if (valids() !== 4'b0010) $display("FAIL single_valid got=%b exp=0010", valids()); else passed++;
        total++; if (bus.unit_transact_o[1].addr !== 32'h40 || bus.unit_transact_o[1].data !== 32'h1111)
            $display("FAIL single_payload got=%h/%h exp=40/1111", bus.unit_transact_o[1].addr, bus.unit_transact_o[1].data);
        else passed++;
        tick();
        total++; if (valids() !== 4'h0 || idle !== 1'b1) $display("FAIL single_drained valids=%b idle=%0b exp=0000/1", valids(), idle); else passed++;
    endtask

    task automatic test_four_units();
        logic [3:0] exp;
        set_ready(4'hF);
        for (int s = 0; s < 6; s++) begin
            if (s < 4) drive(1'b1, 32'(s) << 6, 32'h500 + s);
            else       drive(1'b0, 32'h0, 32'h0);
            tick();
            exp = (s >= 1 && s <= 4) ? (4'b0001 << (s - 1)) : 4'b0000;
            total++; if (valids() !== exp) $display("FAIL four_step%0d got=%b exp=%b", s, valids(), exp); else passed++;
            if (s >= 1 && s <= 4) begin
                total++;
                if (bus.unit_transact_o[s-1].data !== 32'h500 + (s - 1))
                    $display("FAIL four_data%0d got=%h exp=%h", s - 1, bus.unit_transact_o[s-1].data, 32'h500 + (s - 1));
                else passed++;
            end
        end
    endtask

    task automatic test_fill_backpressure();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic r0;
        logic saw_full = 1'b0;
        logic ready_bad = 1'b0;
        set_ready(4'hE);
        while (recv < 12 && cyc < 200) begin
            r0 = (cyc % 4 == 0);
            bus.unit_transact_i[0].ready = r0;
            drive(sent < 12, 32'h100, 32'h700 + sent);
            #1;
            if (occupancy == 4'd8 && bus.transact_o.ready == 1'b0) saw_full = 1'b1;
            if (bus.transact_o.ready !== (occupancy != 4'd8)) ready_bad = 1'b1;
            if (bus.transact_i.valid && bus.transact_o.ready) sent++;
            if (bus.unit_transact_o[0].valid && r0) begin
                total++;
                if (bus.unit_transact_o[0].data !== 32'h700 + recv)
                    $display("FAIL fill_order%0d got=%h exp=%h", recv, bus.unit_transact_o[0].data, 32'h700 + recv);
                else passed++;
                recv++;
            end
            tick();
            cyc++;
        end
        drive(1'b0, 32'h0, 32'h0);
        total++; if (recv !== 12) $display("FAIL fill_count got=%0d exp=12", recv); else passed++;
        total++; if (saw_full !== 1'b1) $display("FAIL fill_full got=%0b exp=1", saw_full); else passed++;
        total++; if (ready_bad !== 1'b0) $display("FAIL fill_ready_vs_occ got=%0b exp=0", ready_bad); else passed++;
        total++; if (!(hol_stall_cnt > 0)) $display("FAIL fill_hol got=%0d exp=>0", hol_stall_cnt); else passed++;
        drain();
    endtask

    task automatic test_push_pop_same_edge();
        set_ready(4'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0, 32'h200 + i);
            tick();
        end
        drive(1'b1, 32'h0, 32'h205);
        bus.unit_transact_i[0].ready = 1'b1;
        #1;
        total++; if (occupancy !== 4'd4) $display("FAIL pp_pre_occ got=%0d exp=4", occupancy); else passed++;
        tick();
        bus.unit_transact_i[0].ready = 1'b0;
        total++; if (occupancy !== 4'd4) $display("FAIL pp_same_edge_occ got=%0d exp=4", occupancy); else passed++;
        total++; if (bus.unit_transact_o[0].data !== 32'h201) $display("FAIL pp_reload got=%h exp=201", bus.unit_transact_o[0].data); else passed++;
        for (int i = 6; i < 10; i++) begin
            drive(1'b1, 32'h0, 32'h200 + i);
            tick();
        end
        drive(1'b1, 32'h0, 32'h20A);
        bus.unit_transact_i[0].ready = 1'b1;
        #1;
        total++; if (occupancy !== 4'd8 || bus.transact_o.ready !== 1'b0)
            $display("FAIL pp_full occ=%0d ready=%0b exp=8/0", occupancy, bus.transact_o.ready);
        else passed++;
        tick();
        drive(1'b0, 32'h0, 32'h0);
        bus.unit_transact_i[0].ready = 1'b0;
        #1;
        total++; if (occupancy !== 4'd7 || bus.transact_o.ready !== 1'b1)
            $display("FAIL pp_after_full occ=%0d ready=%0b exp=7/1", occupancy, bus.transact_o.ready);
        else passed++;
        total++; if (bus.unit_transact_o[0].data !== 32'h202) $display("FAIL pp_after_full_data got=%h exp=202", bus.unit_transact_o[0].data); else passed++;
        drain();
    endtask

    task automatic test_hol_stall();
        logic unstable = 1'b0;
        do_reset();
        set_ready(4'b1011);
        drive(1'b1, 32'h80, 32'hAAAA);
        tick();
        drive(1'b1, 32'h80, 32'hBBBB);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        total++; if (hol_stall_cnt !== 32'd0) $display("FAIL hol_start got=%0d exp=0", hol_stall_cnt); else passed++;
        total++; if (valids() !== 4'b0100 || bus.unit_transact_o[2].data !== 32'hAAAA)
            $display("FAIL hol_slot valids=%b data=%h exp=0100/AAAA", valids(), bus.unit_transact_o[2].data);
        else passed++;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.unit_transact_o[2].valid || bus.unit_transact_o[2].addr !== 32'h80 ||
                bus.unit_transact_o[2].data !== 32'hAAAA) unstable = 1'b1;
        end
        total++; if (unstable !== 1'b0) $display("FAIL hol_stable got=%0b exp=0", unstable); else passed++;
        total++; if (hol_stall_cnt !== 32'd100) $display("FAIL hol_count got=%0d exp=100", hol_stall_cnt); else passed++;
        total++; if (occupancy !== 4'd1) $display("FAIL hol_occ got=%0d exp=1", occupancy); else passed++;
        bus.unit_transact_i[2].ready = 1'b1;
        tick();
        total++; if (bus.unit_transact_o[2].data !== 32'hBBBB || !bus.unit_transact_o[2].valid)
            $display("FAIL hol_next got=%h exp=BBBB", bus.unit_transact_o[2].data);
        else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_single();
        test_four_units();
        test_fill_backpressure();
        test_push_pop_same_edge();
        test_hol_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
